instr_encoder: RTL and testbench
================================

// Module: instr_encoder
// PURPOSE
//  Inverse of the ID-stage decoder: packs structured fields (opcode, funct3/7, 6-bit
//  tagged reg addrs, 32-bit imm) into 32-bit RV32I/F instruction words.
//  Streams the packed words into instruction memory at consecutive word addresses.
//  Acts as the program loader for self-test and boot.
//  Illegal or unencodable beats are dropped and flagged.
// PARAMETERS
//  ADDR_W   14   IM word-address width; address wraps modulo 2**ADDR_W
//  CNT_W    8    width of saturating error counter
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-low
//  start      in   1       begin load session; sampled only in IDLE
//  base_addr  in   ADDR_W  first word address, captured on start
//  in_valid   in   1       field beat valid
//  in_ready   out  1       field beat accepted when in_valid&&in_ready
//  in_last    in   1       final beat of session
//  opcode     in   7       `define.svh opcode
//  funct3     in   3
//  funct7     in   7
//  rd_addr    in   6       bit5=1 FP reg, bit5=0 int reg
//  rs1_addr   in   6       same tagging
//  rs2_addr   in   6       same tagging
//  imm        in   32      full signed immediate, unscaled (byte offset for B/J)
//  im_we      out  1       IM write request
//  im_gnt     in   1       IM accepts write this cycle
//  im_addr    out  ADDR_W  IM word address
//  im_wdata   out  32      packed instruction
//  busy       out  1       state != IDLE
//  done       out  1       1-cycle pulse at session end
//  err        out  1       sticky; any beat dropped this session
//  err_cnt    out  CNT_W   dropped beats, saturates at all-ones
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; stage empty; word index 0.
//  FSM IDLE->LOAD on start (capture base_addr; clear err, err_cnt, index).
//  LOAD->DRAIN on accepted beat with in_last. DRAIN->DONE when stage empty.
//  DONE->IDLE unconditionally; done=1 only in DONE.
//  start outside IDLE is ignored.
//  in_ready = (state==LOAD) && (!stage_v || im_gnt); in_valid is ignored otherwise.
//  One output stage: an accepted legal beat drives im_we=1 next cycle.
//    im_addr = base+index; im_wdata/im_addr held stable while im_we && !im_gnt.
//    On im_gnt: index++ and stage frees the same cycle, giving a back-to-back beat
//    1 word/cycle.
//  Packing: R/FALU = f7|rs2|rs1|f3|rd|op.
//    I/Load/FLW/JALR = imm[11:0]|rs1|f3|rd|op. S/FSW = imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
//    B = imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
//    U(LUI/AUIPC) = imm[31:12]|rd|op. J = imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
//    Reg fields use addr[4:0].
//  Legality (all must hold, else drop):
//    - opcode is in the set above.
//    - Tag bit5: 1 exactly where the decoder expects FP:
//        rd for FLW/FALU; rs2 for FSW/FALU; rs1 for FALU; 0 elsewhere for used fields.
//    - I/S: imm[31:11] all equal. B: imm[31:12] all equal, imm[0]=0.
//      J: imm[31:20] all equal, imm[0]=0. U: imm[11:0]=0.
//    - I-type shift (f3 001/101): imm[11:5] in {0x00,0x20}, imm[31:12]=0.
//  Dropped beat: consumes the handshake, no write, index unchanged; err=1 and
//    err_cnt++ (saturating) the cycle after acceptance.
//    A dropped in_last still ends the session.
//  Index wraps silently at 2**ADDR_W.
//  Reset mid-session: immediate return to IDLE; an in-flight write is abandoned.
// STRUCTURE
//  enc_pkg: state_e {IDLE,LOAD,DRAIN,DONE}; itype_e {R,I,S,B,U,J,ILL}.
//  Opcodes come from `define.svh, not duplicated.
//  Sub-module instr_pack: combinational fields->{word, legal}.
//  Top holds FSM, stage, index and error counter.
// TESTING
//  1. start,base=0x10; ADD x3,x1,x2 -> im_we next cycle, addr 0x10, wdata 0x002081B3.
//  2. B-type BEQ x1,x2,imm=-4 -> 0xFE208EE3. imm=3 -> no write, err=1, err_cnt=1.
//  3. 4 beats with im_gnt low 3 cycles on beat 2 -> wdata/addr stable.
//     Addrs base..base+3 in order, none lost.
//  4. FLW with rd bit5=0 -> dropped; FADD.S all FP tags -> written.
//     done pulses once after the last grant.
//  5. base=2**ADDR_W-1, 2 beats -> addrs max then 0.
//  6. rst low while im_we&&!im_gnt -> all outputs 0 asynchronously.
//     start ignored during busy.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types and RV32I/F base opcodes for the instruction encoder / program loader.
package enc_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_e;
    typedef enum logic [2:0] {R, I, S, B, U, J, ILL} itype_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FLW    = 7'b0000111;
    localparam logic [6:0] OP_FSW    = 7'b0100111;
    localparam logic [6:0] OP_FP     = 7'b1010011;

    function automatic itype_e op_type(input logic [6:0] op);
        itype_e t;
        case (op)
            OP_OP, OP_FP:                      t = R;
            OP_IMM, OP_LOAD, OP_FLW, OP_JALR:  t = I;
            OP_STORE, OP_FSW:                  t = S;
            OP_BRANCH:                         t = B;
            OP_LUI, OP_AUIPC:                  t = U;
            OP_JAL:                            t = J;
            default:                           t = ILL;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: structured fields -> 32-bit RV32I/F word plus legality.
module instr_pack
    import enc_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [5:0]  rd_addr,
    input  logic [5:0]  rs1_addr,
    input  logic [5:0]  rs2_addr,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        legal
);

    itype_e t;
    logic   use_rd, use_rs1, use_rs2;
    logic   fp_rd, fp_rs1, fp_rs2;
    logic   imm_ok, tags_ok;

    assign t = op_type(opcode);

    always_comb begin
        word    = '0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        fp_rd   = 1'b0;
        fp_rs1  = 1'b0;
        fp_rs2  = 1'b0;
        imm_ok  = 1'b0;
        case (t)
            R: begin
                word    = {funct7, rs2_addr[4:0], rs1_addr[4:0], funct3, rd_addr[4:0], opcode};
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                fp_rd   = (opcode == OP_FP);
                fp_rs1  = (opcode == OP_FP);
                fp_rs2  = (opcode == OP_FP);
                imm_ok  = 1'b1;
            end
            I: begin
                word    = {imm[11:0], rs1_addr[4:0], funct3, rd_addr[4:0], opcode};
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                fp_rd   = (opcode == OP_FLW);
                // Shift immediates carry funct7 in imm[11:5]; only SLLI/SRLI/SRAI forms exist.
                if (opcode == OP_IMM && funct3[1:0] == 2'b01)
                    imm_ok = (imm[11:5] == 7'h00 || imm[11:5] == 7'h20) && (imm[31:12] == '0);
                else
                    imm_ok = (&imm[31:11]) || !(|imm[31:11]);
            end
            S: begin
                word    = {imm[11:5], rs2_addr[4:0], rs1_addr[4:0], funct3, imm[4:0], opcode};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                fp_rs2  = (opcode == OP_FSW);
                imm_ok  = (&imm[31:11]) || !(|imm[31:11]);
            end
            B: begin
                word    = {imm[12], imm[10:5], rs2_addr[4:0], rs1_addr[4:0], funct3,
                           imm[4:1], imm[11], opcode};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm_ok  = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
            end
            U: begin
                word    = {imm[31:12], rd_addr[4:0], opcode};
                use_rd  = 1'b1;
                imm_ok  = (imm[11:0] == '0);
            end
            J: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd_addr[4:0], opcode};
                use_rd  = 1'b1;
                imm_ok  = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
            end
            default: begin
                word    = '0;
            end
        endcase
    end

    assign tags_ok = (!use_rd  || (rd_addr[5]  == fp_rd))  &&
                     (!use_rs1 || (rs1_addr[5] == fp_rs1)) &&
                     (!use_rs2 || (rs2_addr[5] == fp_rs2));

    assign legal = (t != ILL) && imm_ok && tags_ok;

endmodule

// File: rtl/instr_encoder.sv
// Program loader: packs field beats into instruction words and streams them to IM.
module instr_encoder
    import enc_pkg::*;
#(
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [5:0]        rd_addr,
    input  logic [5:0]        rs1_addr,
    input  logic [5:0]        rs2_addr,
    input  logic [31:0]       imm,
    output logic              im_we,
    input  logic              im_gnt,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  err_cnt
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              stage_v_q, stage_v_d;
    logic [31:0]       word_q, word_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [31:0] pack_word;
    logic        pack_legal;
    logic        accept;

    instr_pack u_pack (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7   (funct7),
        .rd_addr  (rd_addr),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .imm      (imm),
        .word     (pack_word),
        .legal    (pack_legal)
    );

    assign in_ready = (state_q == LOAD) && (!stage_v_q || im_gnt);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        idx_d     = idx_q;
        stage_v_d = stage_v_q;
        word_d    = word_q;
        err_d     = err_q;
        cnt_d     = cnt_q;

        // Grant retires the staged word first so a new beat can refill it this cycle.
        if (stage_v_q && im_gnt) begin
            stage_v_d = 1'b0;
            idx_d     = idx_q + 1'b1;
        end

        if (accept) begin
            if (pack_legal) begin
                stage_v_d = 1'b1;
                word_d    = pack_word;
            end else begin
                err_d = 1'b1;
                if (cnt_q != '1)
                    cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    base_d  = base_addr;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            LOAD:    if (accept && in_last) state_d = DRAIN;
            DRAIN:   if (!stage_v_q) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            idx_q     <= '0;
            stage_v_q <= 1'b0;
            word_q    <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            idx_q     <= idx_d;
            stage_v_q <= stage_v_d;
            word_q    <= word_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign im_we    = stage_v_q;
    assign im_addr  = base_q + idx_q;
    assign im_wdata = word_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign err      = err_q;
    assign err_cnt  = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table plus scoreboard of IM writes.
module tb_instr_encoder;

    localparam int AW = 14;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          in_valid, in_ready, in_last;
    logic [6:0]    opcode, funct7;
    logic [2:0]    funct3;
    logic [5:0]    rd_addr, rs1_addr, rs2_addr;
    logic [31:0]   imm;
    logic          im_we, im_gnt;
    logic [AW-1:0] im_addr;
    logic [31:0]   im_wdata;
    logic          busy, done, err;
    logic [CW-1:0] err_cnt;

    instr_encoder #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .rd_addr(rd_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .imm(imm),
        .im_we(im_we), .im_gnt(im_gnt), .im_addr(im_addr), .im_wdata(im_wdata),
        .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [5:0]  rd, rs1, rs2;
        logic [31:0] imm;
        bit          legal;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    vec_t          tbl[$];
    wr_t           sb[$];
    int            n_cmp = 0;
    int            n_fail = 0;
    logic [AW-1:0] next_addr;
    int            exp_cnt;

    function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                                logic [5:0] rd, logic [5:0] rs1, logic [5:0] rs2,
                                logic [31:0] im, bit legal, logic [31:0] word);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.imm = im; v.legal = legal; v.word = word;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Every granted write must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (rst === 1'b1 && im_we === 1'b1 && im_gnt === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%04h data 0x%08h, expected none", im_addr, im_wdata);
            end else begin
                wr_t w;
                w = sb.pop_front();
                check("wr_addr", 32'(im_addr), 32'(w.addr));
                check("wr_data", im_wdata, w.data);
            end
        end
    end

    task automatic start_sess(input logic [AW-1:0] b);
        base_addr = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        next_addr = b;
        exp_cnt = 0;
    endtask

    task automatic send(input vec_t v, input bit last);
        opcode = v.op; funct3 = v.f3; funct7 = v.f7;
        rd_addr = v.rd; rs1_addr = v.rs1; rs2_addr = v.rs2; imm = v.imm;
        in_valid = 1'b1;
        in_last = last;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        if (!in_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: in_ready=0, expected 1");
        end else if (v.legal) begin
            wr_t w;
            w.addr = next_addr;
            w.data = v.word;
            sb.push_back(w);
            next_addr = next_addr + 1'b1;
        end else if (exp_cnt < 255) begin
            exp_cnt++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic finish_sess();
        int ndone = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done) ndone++;
            if (!busy) break;
        end
        check("session_ended", 32'(busy), 32'd0);
        check("done_pulses", ndone, 1);
        check("sb_empty", sb.size(), 0);
        check("err", 32'(err), 32'(exp_cnt != 0));
        check("err_cnt", 32'(err_cnt), exp_cnt);
        @(posedge clk); #1;
    endtask

    vec_t v_add, v_beq_m4, v_beq_3, v_addi, v_flw_bad, v_fadd, v_bad_op;
    logic [31:0] hold_data;

    initial begin
        v_add     = mk(7'b0110011, 3'b000, 7'h00, 6'd3, 6'd1, 6'd2, 32'd0, 1, 32'h002081B3);
        v_beq_m4  = mk(7'b1100011, 3'b000, 7'h00, 6'd0, 6'd1, 6'd2, 32'hFFFFFFFC, 1, 32'hFE208EE3);
        v_beq_3   = mk(7'b1100011, 3'b000, 7'h00, 6'd0, 6'd1, 6'd2, 32'd3, 0, 32'h0);
        v_addi    = mk(7'b0010011, 3'b000, 7'h00, 6'd5, 6'd6, 6'd0, 32'hFFFFFFFF, 1, 32'hFFF30293);
        v_flw_bad = mk(7'b0000111, 3'b010, 7'h00, 6'd1, 6'd2, 6'd0, 32'd4, 0, 32'h0);
        v_fadd    = mk(7'b1010011, 3'b000, 7'h00, 6'h21, 6'h22, 6'h23, 32'd0, 1, 32'h003100D3);
        v_bad_op  = mk(7'b1111111, 3'b000, 7'h00, 6'd1, 6'd1, 6'd1, 32'd0, 0, 32'h0);

        tbl.push_back(v_add);
        tbl.push_back(v_beq_m4);
        tbl.push_back(v_beq_3);
        tbl.push_back(v_addi);
        tbl.push_back(mk(7'b0100011, 3'b010, 7'h00, 6'd0, 6'd1, 6'd2, 32'd8, 1, 32'h0020A423));
        tbl.push_back(mk(7'b0110111, 3'b000, 7'h00, 6'd5, 6'd0, 6'd0, 32'h12345000, 1, 32'h123452B7));
        tbl.push_back(mk(7'b0110111, 3'b000, 7'h00, 6'd5, 6'd0, 6'd0, 32'h12345001, 0, 32'h0));
        tbl.push_back(mk(7'b1101111, 3'b000, 7'h00, 6'd1, 6'd0, 6'd0, 32'd8, 1, 32'h008000EF));
        tbl.push_back(mk(7'b0010011, 3'b001, 7'h00, 6'd1, 6'd2, 6'd0, 32'h003, 1, 32'h00311093));
        tbl.push_back(mk(7'b0010011, 3'b101, 7'h00, 6'd1, 6'd2, 6'd0, 32'h403, 1, 32'h40315093));
        tbl.push_back(mk(7'b0010011, 3'b001, 7'h00, 6'd1, 6'd2, 6'd0, 32'h203, 0, 32'h0));
        tbl.push_back(mk(7'b0000111, 3'b010, 7'h00, 6'h21, 6'd2, 6'd0, 32'd4, 1, 32'h00412087));
        tbl.push_back(v_flw_bad);
        tbl.push_back(v_fadd);
        tbl.push_back(mk(7'b0100111, 3'b010, 7'h00, 6'd0, 6'd1, 6'h22, 32'd0, 1, 32'h0020A027));
        tbl.push_back(mk(7'b0100111, 3'b010, 7'h00, 6'd0, 6'd1, 6'd2, 32'd0, 0, 32'h0));
        tbl.push_back(mk(7'b0110011, 3'b000, 7'h00, 6'd3, 6'h21, 6'd2, 32'd0, 0, 32'h0));
        tbl.push_back(v_bad_op);
        tbl.push_back(mk(7'b0010011, 3'b000, 7'h00, 6'd5, 6'd6, 6'd0, 32'h800, 0, 32'h0));
        tbl.push_back(mk(7'b1100011, 3'b000, 7'h00, 6'd0, 6'd1, 6'd2, 32'h1000, 0, 32'h0));
        tbl.push_back(mk(7'b1100111, 3'b000, 7'h00, 6'd0, 6'd1, 6'd0, 32'd0, 1, 32'h00008067));
        tbl.push_back(mk(7'b0010111, 3'b000, 7'h00, 6'd1, 6'd0, 6'd0, 32'hFFFFF000, 1, 32'hFFFFF097));

        rst = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        opcode = '0; funct3 = '0; funct7 = '0; rd_addr = '0; rs1_addr = '0; rs2_addr = '0;
        imm = '0; im_gnt = 1'b1;
        #12;
        check("rst_im_we", 32'(im_we), 0);
        check("rst_im_addr", 32'(im_addr), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // 1. single ADD: write appears the cycle after acceptance
        start_sess(14'h10);
        im_gnt = 1'b0;
        send(v_add, 1'b1);
        check("t1_im_we", 32'(im_we), 1);
        check("t1_im_addr", 32'(im_addr), 32'h10);
        check("t1_im_wdata", im_wdata, 32'h002081B3);
        im_gnt = 1'b1;
        finish_sess();

        // 2. branch legality and error timing
        start_sess(14'h20);
        send(v_add, 1'b0);
        send(v_beq_m4, 1'b0);
        check("t2_err_before", 32'(err), 0);
        send(v_beq_3, 1'b1);
        check("t2_err_after", 32'(err), 1);
        check("t2_cnt_after", 32'(err_cnt), 1);
        finish_sess();

        // full vector table in one session
        start_sess(14'h100);
        for (int i = 0; i < tbl.size(); i++)
            send(tbl[i], i == tbl.size() - 1);
        finish_sess();

        // 3. stalled grant on a back-to-back beat
        start_sess(14'h40);
        send(v_add, 1'b0);
        send(v_beq_m4, 1'b0);
        im_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_hold_we", 32'(im_we), 1);
            check("t3_hold_addr", 32'(im_addr), 32'h41);
            check("t3_hold_data", im_wdata, 32'hFE208EE3);
        end
        @(posedge clk); #1;
        im_gnt = 1'b1;
        send(v_addi, 1'b0);
        send(v_fadd, 1'b1);
        finish_sess();

        // 4. FLW with integer rd dropped, FADD.S written
        start_sess(14'h80);
        send(v_flw_bad, 1'b0);
        send(v_fadd, 1'b1);
        finish_sess();

        // 5. address wrap
        start_sess(14'h3FFF);
        send(v_add, 1'b0);
        send(v_addi, 1'b1);
        finish_sess();

        // error counter saturation; last beat dropped still ends session
        start_sess(14'h0);
        for (int i = 0; i < 260; i++)
            send(v_bad_op, i == 259);
        finish_sess();
        check("sat_cnt", 32'(err_cnt), 32'hFF);

        // 6. start ignored while busy, then async reset during a stalled write
        start_sess(14'h100);
        im_gnt = 1'b0;
        send(v_add, 1'b0);
        base_addr = 14'h200;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("t6_busy", 32'(busy), 1);
        check("t6_addr_kept", 32'(im_addr), 32'h100);
        check("t6_we", 32'(im_we), 1);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        check("t6_rst_we", 32'(im_we), 0);
        check("t6_rst_addr", 32'(im_addr), 0);
        check("t6_rst_wdata", im_wdata, 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_done", 32'(done), 0);
        check("t6_rst_err", 32'(err), 0);
        check("t6_rst_cnt", 32'(err_cnt), 0);
        check("t6_rst_ready", 32'(in_ready), 0);
        sb.delete();
        im_gnt = 1'b1;
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("t6_idle", 32'(busy), 0);

        // reload after reset works normally
        start_sess(14'h5);
        send(v_beq_m4, 1'b1);
        finish_sess();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
